// File: rtl/seq_det_pkg.sv
// Shared types and helpers for the programmable serial sequence detector.
package seq_det_pkg;

  localparam int DEF_MAX_LEN = 8;
  localparam int DEF_CNT_W   = 8;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Requested lengths outside 1..max_len fold to the nearest legal value.
  function automatic int clamp_len(input int len, input int max_len);
    int res;
    if (len < 1) begin
      res = 1;
    end else if (len > max_len) begin
      res = max_len;
    end else begin
      res = len;
    end
    return res;
  endfunction

endpackage

// File: rtl/seq_det_match.sv
// Bit history, fill tracking and masked pattern compare; hit is combinational
// and only asserts on a cycle where a bit is shifted in.
module seq_det_match
  import seq_det_pkg::*;
#(
  parameter int MAX_LEN = DEF_MAX_LEN,
  parameter int LEN_W   = $clog2(MAX_LEN + 1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clr,
  input  logic               shift,
  input  logic               din,
  input  logic [MAX_LEN-1:0] pattern,
  input  logic [LEN_W-1:0]   len,
  input  logic               overlap,
  output logic               hit
);

  logic [MAX_LEN-1:0] history_q, history_d;
  logic [MAX_LEN-1:0] hist_next;
  logic [MAX_LEN-1:0] mask;
  logic [LEN_W-1:0]   fill_q, fill_d;
  logic [LEN_W:0]     fill_inc;
  logic               full;

  always_comb begin
    hist_next = {history_q[MAX_LEN-2:0], din};
    fill_inc  = {1'b0, fill_q} + (LEN_W + 1)'(1);
    full      = (fill_inc >= {1'b0, len});
    for (int i = 0; i < MAX_LEN; i++) begin
      mask[i] = (i < int'(len));
    end
    hit = shift && full && (((hist_next ^ pattern) & mask) == '0);

    history_d = history_q;
    fill_d    = fill_q;
    if (clr) begin
      history_d = '0;
      fill_d    = '0;
    end else if (shift) begin
      history_d = hist_next;
      // Non-overlapping mode forgets every bit that formed the match.
      if (hit && !overlap) begin
        fill_d = '0;
      end else if (full) begin
        fill_d = len;
      end else begin
        fill_d = fill_inc[LEN_W-1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      history_q <= '0;
      fill_q    <= '0;
    end else begin
      history_q <= history_d;
      fill_q    <= fill_d;
    end
  end

endmodule

// File: rtl/seq_det_ctrl.sv
// Sequence-detector controller: config capture, IDLE/RUN control, registered
// match pulse and saturating match counter.
module seq_det_ctrl
  import seq_det_pkg::*;
#(
  parameter int MAX_LEN = DEF_MAX_LEN,
  parameter int CNT_W   = DEF_CNT_W,
  parameter int LEN_W   = $clog2(MAX_LEN + 1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cfg_valid,
  output logic               cfg_ready,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_overlap,
  input  logic               start,
  input  logic               stop,
  input  logic               din,
  input  logic               din_valid,
  output logic               busy,
  output logic               match,
  output logic [CNT_W-1:0]   match_count,
  output logic               count_sat
);

  state_t             state_q, state_d;
  logic [MAX_LEN-1:0] pattern_q, pattern_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic               overlap_q, overlap_d;
  logic               match_q, match_d;
  logic [CNT_W-1:0]   match_count_q, match_count_d;
  logic               count_sat_q, count_sat_d;
  logic               hit;
  logic               clr;
  logic               shift;

  assign clr   = (state_q == IDLE) && start;
  assign shift = (state_q == RUN) && din_valid && !stop;

  seq_det_match #(
    .MAX_LEN (MAX_LEN),
    .LEN_W   (LEN_W)
  ) u_match (
    .clk     (clk),
    .reset   (reset),
    .clr     (clr),
    .shift   (shift),
    .din     (din),
    .pattern (pattern_q),
    .len     (len_q),
    .overlap (overlap_q),
    .hit     (hit)
  );

  always_comb begin
    state_d       = state_q;
    pattern_d     = pattern_q;
    len_d         = len_q;
    overlap_d     = overlap_q;
    match_d       = hit;
    match_count_d = match_count_q;
    count_sat_d   = count_sat_q;
    case (state_q)
      IDLE: begin
        // Config and start in the same cycle: RUN sees the new config.
        if (cfg_valid) begin
          pattern_d = cfg_pattern;
          len_d     = LEN_W'(clamp_len(int'(cfg_len), MAX_LEN));
          overlap_d = cfg_overlap;
        end
        if (start) begin
          state_d       = RUN;
          match_count_d = '0;
          count_sat_d   = 1'b0;
        end
      end
      RUN: begin
        if (stop) begin
          state_d = IDLE;
        end
        if (hit) begin
          if (&match_count_q) begin
            count_sat_d = 1'b1;
          end else begin
            match_count_d = match_count_q + CNT_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      pattern_q     <= '0;
      len_q         <= LEN_W'(1);
      overlap_q     <= 1'b0;
      match_q       <= 1'b0;
      match_count_q <= '0;
      count_sat_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      pattern_q     <= pattern_d;
      len_q         <= len_d;
      overlap_q     <= overlap_d;
      match_q       <= match_d;
      match_count_q <= match_count_d;
      count_sat_q   <= count_sat_d;
    end
  end

  assign cfg_ready   = (state_q == IDLE);
  assign busy        = (state_q == RUN);
  assign match       = match_q;
  assign match_count = match_count_q;
  assign count_sat   = count_sat_q;

endmodule

// File: tb/tb_seq_det_ctrl.sv
// Directed bench for seq_det_ctrl with a queue-based reference model checked
// every cycle, plus literal expectations at key points.
module tb_seq_det_ctrl;

  localparam int MAX_LEN = 8;
  localparam int CNT_W   = 2;
  localparam int LEN_W   = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic               cfg_valid = 1'b0;
  logic               cfg_ready;
  logic [MAX_LEN-1:0] cfg_pattern = '0;
  logic [LEN_W-1:0]   cfg_len = '0;
  logic               cfg_overlap = 1'b0;
  logic               start = 1'b0;
  logic               stop = 1'b0;
  logic               din = 1'b0;
  logic               din_valid = 1'b0;
  logic               busy;
  logic               match;
  logic [CNT_W-1:0]   match_count;
  logic               count_sat;

  int tests = 0;
  int fails = 0;
  bit chk_on = 1'b0;

  seq_det_ctrl #(.MAX_LEN(MAX_LEN), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .reset       (reset),
    .cfg_valid   (cfg_valid),
    .cfg_ready   (cfg_ready),
    .cfg_pattern (cfg_pattern),
    .cfg_len     (cfg_len),
    .cfg_overlap (cfg_overlap),
    .start       (start),
    .stop        (stop),
    .din         (din),
    .din_valid   (din_valid),
    .busy        (busy),
    .match       (match),
    .match_count (match_count),
    .count_sat   (count_sat)
  );

  always #5 clk = ~clk;

  // Reference model: the queue holds the accepted bits still eligible for a match.
  bit           q[$];
  bit           m_run = 0, m_ovl = 0, m_match = 0, m_sat = 0;
  int           m_len = 1, m_cnt = 0;
  logic [7:0]   m_pat = '0;

  function automatic bit tail_matches();
    for (int i = 0; i < m_len; i++) begin
      if (q[i] != m_pat[m_len-1-i]) return 1'b0;
    end
    return 1'b1;
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      m_run = 0; m_pat = '0; m_len = 1; m_ovl = 0;
      q.delete(); m_match = 0; m_cnt = 0; m_sat = 0;
    end else begin
      m_match = 0;
      if (!m_run) begin
        if (cfg_valid) begin
          m_pat = cfg_pattern;
          m_len = (cfg_len == 0) ? 1 : ((int'(cfg_len) > MAX_LEN) ? MAX_LEN : int'(cfg_len));
          m_ovl = cfg_overlap;
        end
        if (start) begin
          m_run = 1; q.delete(); m_cnt = 0; m_sat = 0;
        end
      end else if (stop) begin
        m_run = 0;
      end else if (din_valid) begin
        q.push_back(din);
        while (q.size() > m_len) void'(q.pop_front());
        if (q.size() == m_len && tail_matches()) begin
          m_match = 1;
          if (m_cnt == CNT_MAX) m_sat = 1;
          else m_cnt++;
          if (!m_ovl) q.delete();
        end
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_on) begin
      chk("model_cfg_ready", int'(cfg_ready), int'(!m_run));
      chk("model_busy", int'(busy), int'(m_run));
      chk("model_match", int'(match), int'(m_match));
      chk("model_count", int'(match_count), m_cnt);
      chk("model_sat", int'(count_sat), int'(m_sat));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic configure(input logic [7:0] pat, input int len, input bit ovl);
    cfg_valid = 1; cfg_pattern = pat; cfg_len = LEN_W'(len); cfg_overlap = ovl;
    tick();
    cfg_valid = 0;
  endtask

  task automatic arm();
    start = 1; tick(); start = 0;
  endtask

  task automatic disarm();
    stop = 1; tick(); stop = 0;
  endtask

  task automatic send(input bit b);
    din = b; din_valid = 1; tick(); din_valid = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, tests=%0d", tests);
    $fatal(1, "timeout");
  end

  initial begin
    tick();
    chk_on = 1;
    tick();
    reset = 0;
    chk("reset_cfg_ready", int'(cfg_ready), 1);
    chk("reset_count", int'(match_count), 0);

    // 011, non-overlapping: pulses after bits 3 and 6
    configure(8'b011, 3, 0);
    arm();
    send(0); send(1); send(1);
    chk("p011_match3", int'(match), 1);
    send(0);
    chk("p011_match4", int'(match), 0);
    send(1); send(1);
    chk("p011_match6", int'(match), 1);
    chk("p011_count", int'(match_count), 2);
    disarm();

    // 11 on stream 1111: overlap vs not
    configure(8'b11, 2, 1);
    arm();
    repeat (4) send(1);
    chk("ovl_count", int'(match_count), 3);
    disarm();
    configure(8'b11, 2, 0);
    arm();
    send(1); chk("novl_b1", int'(match), 0);
    send(1); chk("novl_b2", int'(match), 1);
    send(1); chk("novl_b3", int'(match), 0);
    send(1); chk("novl_b4", int'(match), 1);
    chk("novl_count", int'(match_count), 2);
    disarm();

    // Saturation with a 2-bit counter
    configure(8'b1, 1, 1);
    arm();
    repeat (3) send(1);
    chk("sat_cnt3", int'(match_count), 3);
    chk("sat_not_yet", int'(count_sat), 0);
    send(1);
    chk("sat_set", int'(count_sat), 1);
    send(1);
    chk("sat_hold", int'(match_count), 3);
    disarm();
    chk("sat_idle_hold", int'(count_sat), 1);
    arm();
    chk("restart_count", int'(match_count), 0);
    chk("restart_sat", int'(count_sat), 0);
    disarm();

    // din_valid gaps
    configure(8'b011, 3, 0);
    arm();
    send(0); tick();
    chk("gap_nomatch", int'(match), 0);
    send(1); tick(); tick();
    send(1);
    chk("gap_match", int'(match), 1);
    tick();
    chk("gap_pulse_end", int'(match), 0);

    // cfg in RUN is ignored
    cfg_valid = 1; cfg_pattern = 8'b1; cfg_len = 4'd1;
    tick();
    chk("run_cfg_ready", int'(cfg_ready), 0);
    cfg_valid = 0;
    send(1);
    chk("run_cfg_ignored", int'(match), 0);
    disarm();

    // cfg_len 0 -> length 1; cfg_len 12 -> length 8
    configure(8'h01, 0, 0);
    arm();
    send(0); chk("len0_nomatch", int'(match), 0);
    send(1); chk("len0_match", int'(match), 1);
    disarm();
    configure(8'hA5, 12, 0);
    arm();
    send(1); send(0); send(1); send(0); send(0); send(1); send(0);
    chk("len12_early", int'(match), 0);
    send(1);
    chk("len12_match", int'(match), 1);
    disarm();

    // Reset mid-RUN clears config
    configure(8'b011, 3, 0);
    arm();
    send(0); send(1);
    reset = 1; tick(); reset = 0;
    chk("rst_busy", int'(busy), 0);
    chk("rst_count", int'(match_count), 0);
    arm();
    send(0);
    chk("rst_cfg_default", int'(match), 1);
    disarm();

    // stop with the completing bit discards it
    configure(8'b011, 3, 0);
    arm();
    send(0); send(1);
    din = 1; din_valid = 1; stop = 1;
    tick();
    din_valid = 0; stop = 0;
    chk("stop_discard", int'(match), 0);
    chk("stop_idle", int'(busy), 0);

    // Match earned just before stop still pulses
    arm();
    send(0); send(1); send(1);
    disarm();
    tick();

    chk_on = 0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
